// File: rtl/ste_pkg.sv
// Shared types and arithmetic helpers for the peak-hold/decay tracker.
package ste_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        DECAY = 2'd2
    } ste_ph_state_t;

    // Magnitude of a sign-extended sample of width w, saturated to w-1 bits
    // so the most negative code maps to the largest positive magnitude.
    function automatic logic [31:0] abs_sat(input logic signed [31:0] sample, input int w);
        logic [31:0] mag;
        logic [31:0] lim;
        lim = (32'd1 << (w - 1)) - 32'd1;
        mag = (sample < 0) ? 32'(-sample) : 32'(sample);
        return (mag > lim) ? lim : mag;
    endfunction

    function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? (a - b) : 32'd0;
    endfunction

endpackage

// File: rtl/ste_peak_hold.sv
// Absolute-peak tracker with hold and linear decay, paced by valid samples,
// feeding a scaled level and update strobe to the bar display.
module ste_peak_hold
    import ste_pkg::*;
#(
    parameter int SMPL_W      = 12,
    parameter int DATA_W      = 4,
    parameter int UPD_SAMPLES = 4,
    parameter int HOLD_TICKS  = 2,
    parameter int DECAY_STEP  = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SMPL_W-1:0] smpl_i,
    input  logic              smpl_valid_i,
    input  logic              clr_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              dout_update_o,
    output logic              clr_o,
    output logic [SMPL_W-2:0] peak_o
);

    localparam int CNT_W = (UPD_SAMPLES > 1) ? $clog2(UPD_SAMPLES) : 1;
    localparam int HLD_W = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

    ste_ph_state_t     state, state_next;
    logic [SMPL_W-2:0] peak, peak_next, base, mag;
    logic [HLD_W-1:0]  hold_cnt, hold_next;
    logic [CNT_W-1:0]  smp_cnt;
    logic              tick;

    assign mag  = (SMPL_W-1)'(abs_sat({{(32-SMPL_W){smpl_i[SMPL_W-1]}}, smpl_i}, SMPL_W));
    assign tick = smpl_valid_i && (smp_cnt == CNT_W'(UPD_SAMPLES - 1));

    always_comb begin
        base       = peak;
        hold_next  = hold_cnt;
        state_next = state;
        if (tick) begin
            if (state == DECAY || (state == HOLD && hold_cnt == '0)) begin
                base       = (SMPL_W-1)'(sat_sub(32'(peak), 32'(DECAY_STEP)));
                state_next = DECAY;
            end else if (state == HOLD) begin
                hold_next = hold_cnt - HLD_W'(1);
            end
        end
        // A new sample at or above the (possibly decayed) base restarts the hold.
        if (smpl_valid_i && mag != '0 && mag >= base) begin
            peak_next  = mag;
            hold_next  = HLD_W'(HOLD_TICKS);
            state_next = HOLD;
        end else begin
            peak_next = base;
        end
        if (peak_next == '0) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            peak          <= '0;
            hold_cnt      <= '0;
            smp_cnt       <= '0;
            state         <= IDLE;
            dout_o        <= '0;
            dout_update_o <= 1'b0;
            clr_o         <= 1'b0;
        end else if (clr_i) begin
            peak          <= '0;
            hold_cnt      <= '0;
            smp_cnt       <= '0;
            state         <= IDLE;
            dout_o        <= '0;
            dout_update_o <= 1'b1;
            clr_o         <= 1'b1;
        end else begin
            peak          <= peak_next;
            hold_cnt      <= hold_next;
            state         <= state_next;
            dout_update_o <= tick;
            clr_o         <= 1'b0;
            if (smpl_valid_i) smp_cnt <= tick ? '0 : smp_cnt + CNT_W'(1);
            if (tick) dout_o <= peak_next[SMPL_W-2 -: DATA_W];
        end
    end

    assign peak_o = peak;

endmodule

// File: doc/ste_peak_hold.md
Name: ste_peak_hold

Overview:
- Peak-hold/decay tracker for the multimeter bar-graph path.
- Sits directly upstream of the LED bar stage: consumes the signed measurement sample stream and tracks the absolute peak with a hold time and linear decay.
- Emits a scaled DATA_W-bit level plus a one-cycle update strobe, i.e. the din/din_update/clr feed of the bar display.

Parameters:
SMPL_W, 12, input sample width, signed two's complement
DATA_W, 4, output level width; constraint DATA_W <= SMPL_W-1
UPD_SAMPLES, 4, valid samples per output update tick (>=1)
HOLD_TICKS, 2, update ticks the peak is held before decay starts (>=0)
DECAY_STEP, 128, magnitude subtracted per tick in DECAY (SMPL_W-1 bits, >=1)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
smpl_i  in  SMPL_W  signed input sample
smpl_valid_i  in  1  sample qualifier, one sample per high cycle
clr_i  in  1  synchronous clear of peak state
dout_o  out  DATA_W  scaled peak level to bar display
dout_update_o  out  1  one-cycle strobe, dout_o new
clr_o  out  1  registered copy of clr_i for downstream clear
peak_o  out  SMPL_W-1  full-resolution peak register

Behaviour:
- Reset (rst_n=0 at clk edge): peak=0, hold_cnt=0, smp_cnt=0, state=IDLE, dout_o=0, dout_update_o=0, clr_o=0, peak_o=0.
- mag = |smpl_i|, width SMPL_W-1; most negative value saturates (-2048 -> 2047 for SMPL_W=12).
- tick = smpl_valid_i && smp_cnt==UPD_SAMPLES-1.
- smp_cnt increments on each valid sample and wraps to 0 on tick.
- States:
  - IDLE: peak==0.
  - HOLD: peak held, hold_cnt counting.
  - DECAY: peak decremented each tick.
- base:
  - On tick, if state==DECAY or (state==HOLD and hold_cnt==0): base = sat_sub(peak, DECAY_STEP), floored at 0, and state -> DECAY.
  - On tick, if state==HOLD and hold_cnt>0: hold_cnt decrements and base = peak.
  - Otherwise base = peak.
- Capture: smpl_valid_i && mag!=0 && mag>=base -> peak_next=mag, hold_cnt=HOLD_TICKS, state=HOLD. Capture overrides the same-cycle decay and decrement. Otherwise peak_next=base.
- peak_next==0 -> state=IDLE.
- dout_o registered on tick: peak_next[SMPL_W-2 -: DATA_W], truncated, no rounding.
- dout_update_o = tick delayed by 1 cycle. Latency is one cycle from the tick sample edge; the output includes that sample.
- dout_o is stable between strobes. peak_o follows the peak register every cycle.
- clr_i has priority over everything:
  - peak, hold_cnt and smp_cnt go to 0; state=IDLE.
  - Next cycle: dout_o=0, dout_update_o=1, clr_o=1 for one cycle.
  - A sample arriving in the clr_i cycle is discarded.
- Multi-cycle clr_i: state stays cleared; strobe repeats each cycle clr_i is high.
- No valid samples: no ticks, state frozen. Decay is paced by the sample rate, not by clk.
- UPD_SAMPLES=1: every valid sample is a tick.
- HOLD_TICKS=0: decay starts on the first tick after capture.

Decomposition:
- Package ste_pkg holds:
  - state enum ste_ph_state_t {IDLE, HOLD, DECAY}.
  - Function abs_sat(sample) returning an SMPL_W-1 bit magnitude.
  - Function sat_sub.
- No sub-module needed; a single always_ff block plus next-state logic is sufficient.

Test Plan (SMPL_W=12, DATA_W=4, UPD_SAMPLES=4, HOLD_TICKS=2, DECAY_STEP=128):
1. Reset: hold rst_n=0 for 2 cycles while driving samples -> all outputs 0, no strobe.
2. Capture: valid samples +1000,0,0,0 -> dout_update_o one cycle after the 4th sample, dout_o=7, peak_o=1000. Then sample -2048 in the next window -> peak_o=2047, dout_o=15.
3. Hold/decay after capture of 1000, then zeros -> successive strobes give peak_o 1000,1000,872,744 and dout_o 7,7,6,5.
4. Decay floor: peak 100 in DECAY, next tick -> peak_o=0, dout_o=0, state IDLE. Further zero-sample ticks keep dout_o=0.
5. Recapture: in DECAY at 744, valid sample 900 -> peak_o=900 next cycle. The next two ticks hold 900; decay resumes on the third.
6. Clear collision: clr_i high in the same cycle as tick sample 1500 -> next cycle dout_o=0, dout_update_o=1, clr_o=1, peak_o=0. smp_cnt restarts, so the next strobe comes after 4 further samples.
